// File: rtl/rename_pkg.sv
// Shared rename/issue types: ROB tag width, physical register width and the
// issue-queue entry record used by the collapsing issue queue.
package rename_pkg;

  localparam int unsigned ROB_DEPTH_BITS   = 5;
  localparam int unsigned PHY_REG_BITS     = 6;
  // Entry payload storage is sized for the widest micro-op encoding in use;
  // each queue instance carries only its low PAYLOAD_W bits.
  localparam int unsigned IQ_PAYLOAD_MAX_W = 64;

  typedef logic [ROB_DEPTH_BITS-1:0] rob_tag_t;
  typedef logic [PHY_REG_BITS-1:0]   phy_reg_t;

  typedef struct packed {
    logic                        valid;
    phy_reg_t                    rs_phy;
    logic                        rs_ready;
    rob_tag_t                    rs_tag;
    phy_reg_t                    rt_phy;
    logic                        rt_ready;
    rob_tag_t                    rt_tag;
    phy_reg_t                    rw_phy;
    logic                        uses_rw;
    rob_tag_t                    rob_tag;
    logic [IQ_PAYLOAD_MAX_W-1:0] payload;
  } iq_entry_t;

  function automatic iq_entry_t iq_wake(input iq_entry_t e, input logic wb_valid,
                                        input rob_tag_t wb_tag);
    iq_entry_t r;
    r = e;
    if (wb_valid && e.valid) begin
      if (!e.rs_ready && (e.rs_tag == wb_tag)) r.rs_ready = 1'b1;
      if (!e.rt_ready && (e.rt_tag == wb_tag)) r.rt_ready = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_select.sv
// Lowest-index priority picker: one-hot grant, binary index and any flag
// for an N-bit eligible vector.
module iq_select #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         eligible,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IDX_W = $clog2(N);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (eligible[i] && !any) begin
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Collapsing oldest-first issue queue behind register rename: slot 0 is the
// oldest, sources wake on ROB writeback broadcasts, oldest ready entry issues.
module issue_queue
  import rename_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PAYLOAD_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PHY_REG_BITS-1:0]     in_rs_phy,
  input  logic [PHY_REG_BITS-1:0]     in_rt_phy,
  input  logic                        in_rs_ready,
  input  logic                        in_rt_ready,
  input  logic [ROB_DEPTH_BITS-1:0]   in_rs_tag,
  input  logic [ROB_DEPTH_BITS-1:0]   in_rt_tag,
  input  logic [PHY_REG_BITS-1:0]     in_rw_phy,
  input  logic                        in_uses_rw,
  input  logic [ROB_DEPTH_BITS-1:0]   in_rob_tag,
  input  logic [PAYLOAD_W-1:0]        in_payload,
  input  logic                        wb_valid,
  input  logic [ROB_DEPTH_BITS-1:0]   wb_tag,
  output logic                        iss_valid,
  input  logic                        iss_ready,
  output logic [PHY_REG_BITS-1:0]     iss_rs_phy,
  output logic [PHY_REG_BITS-1:0]     iss_rt_phy,
  output logic [PHY_REG_BITS-1:0]     iss_rw_phy,
  output logic                        iss_uses_rw,
  output logic [ROB_DEPTH_BITS-1:0]   iss_rob_tag,
  output logic [PAYLOAD_W-1:0]        iss_payload,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  iq_entry_t        q      [DEPTH];
  iq_entry_t        q_nxt  [DEPTH];
  iq_entry_t        woken  [DEPTH];
  iq_entry_t        above  [DEPTH];
  iq_entry_t        new_entry;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] enq_slot;
  logic [DEPTH-1:0] eligible;
  logic [DEPTH-1:0] sel_grant;
  logic [DEPTH-1:0] shift;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             issue;
  logic             enq;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      eligible[i] = q[i].valid && q[i].rs_ready && q[i].rt_ready;
    end
  end

  iq_select #(.N(DEPTH)) u_select (
    .eligible (eligible),
    .grant    (sel_grant),
    .idx      (sel_idx),
    .any      (sel_any)
  );

  assign count     = count_q;
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign iss_valid = sel_any;
  assign issue     = sel_any && iss_ready;
  assign enq       = in_valid && in_ready && !flush;
  // With a simultaneous issue the whole queue collapses by one first.
  assign enq_slot  = issue ? (count_q - CNT_W'(1)) : count_q;

  assign iss_rs_phy  = q[sel_idx].rs_phy;
  assign iss_rt_phy  = q[sel_idx].rt_phy;
  assign iss_rw_phy  = q[sel_idx].rw_phy;
  assign iss_uses_rw = q[sel_idx].uses_rw;
  assign iss_rob_tag = q[sel_idx].rob_tag;
  assign iss_payload = q[sel_idx].payload[PAYLOAD_W-1:0];

  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.rs_phy   = in_rs_phy;
    new_entry.rs_ready = in_rs_ready || (wb_valid && (wb_tag == in_rs_tag));
    new_entry.rs_tag   = in_rs_tag;
    new_entry.rt_phy   = in_rt_phy;
    new_entry.rt_ready = in_rt_ready || (wb_valid && (wb_tag == in_rt_tag));
    new_entry.rt_tag   = in_rt_tag;
    new_entry.rw_phy   = in_rw_phy;
    new_entry.uses_rw  = in_uses_rw;
    new_entry.rob_tag  = in_rob_tag;
    new_entry.payload  = IQ_PAYLOAD_MAX_W'(in_payload);
  end

  // Slots at and above the granted one take their upper neighbour, with that
  // neighbour's wakeup from this cycle already folded in.
  always_comb begin
    logic run;
    run   = 1'b0;
    shift = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      run      = run || sel_grant[i];
      shift[i] = issue && run;
      woken[i] = iq_wake(q[i], wb_valid, wb_tag);
    end
    above[DEPTH-1] = '0;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      above[i] = woken[i+1];
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      q_nxt[i] = shift[i] ? above[i] : woken[i];
      if (enq && (CNT_W'(i) == enq_slot)) q_nxt[i] = new_entry;
      if (flush) q_nxt[i] = '0;
    end
  end

  always_comb begin
    count_nxt = count_q;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({enq, issue})
        2'b10:   count_nxt = count_q + CNT_W'(1);
        2'b01:   count_nxt = count_q - CNT_W'(1);
        default: count_nxt = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      count_q <= count_nxt;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q[i] <= q_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: per-cycle vector table plus hand-built
// sequences, with a scoreboard checking issued fields against enqueued ones.
module tb_issue_queue;
  import rename_pkg::*;

  localparam int DEPTH = 8;
  localparam int PW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  typedef logic [ROB_DEPTH_BITS-1:0] tag_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [PHY_REG_BITS-1:0]   in_rs_phy, in_rt_phy, in_rw_phy;
  logic                      in_rs_ready, in_rt_ready, in_uses_rw;
  tag_t                      in_rs_tag, in_rt_tag, in_rob_tag;
  logic [PW-1:0]             in_payload;
  logic                      wb_valid;
  tag_t                      wb_tag;
  logic                      iss_valid;
  logic                      iss_ready;
  logic [PHY_REG_BITS-1:0]   iss_rs_phy, iss_rt_phy, iss_rw_phy;
  logic                      iss_uses_rw;
  tag_t                      iss_rob_tag;
  logic [PW-1:0]             iss_payload;
  logic [CW-1:0]             count;

  issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_phy(in_rs_phy), .in_rt_phy(in_rt_phy),
    .in_rs_ready(in_rs_ready), .in_rt_ready(in_rt_ready),
    .in_rs_tag(in_rs_tag), .in_rt_tag(in_rt_tag),
    .in_rw_phy(in_rw_phy), .in_uses_rw(in_uses_rw),
    .in_rob_tag(in_rob_tag), .in_payload(in_payload),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs_phy(iss_rs_phy), .iss_rt_phy(iss_rt_phy), .iss_rw_phy(iss_rw_phy),
    .iss_uses_rw(iss_uses_rw), .iss_rob_tag(iss_rob_tag), .iss_payload(iss_payload),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic in_valid;
    tag_t rob;
    logic rs_rdy;
    tag_t rs_tag;
    logic rt_rdy;
    tag_t rt_tag;
    logic wb_v;
    tag_t wb_tag;
    logic iss_rdy;
    logic flush;
    int   e_cnt;
    logic e_iv;
    tag_t e_tag;
  } vec_t;

  typedef struct {
    tag_t                    rob;
    logic [PHY_REG_BITS-1:0] rs, rt, rw;
    logic                    urw;
    logic [PW-1:0]           pl;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [PHY_REG_BITS-1:0] f_rs(tag_t t); return PHY_REG_BITS'(t * 2 + 1); endfunction
  function automatic logic [PHY_REG_BITS-1:0] f_rt(tag_t t); return PHY_REG_BITS'(t * 3 + 2); endfunction
  function automatic logic [PHY_REG_BITS-1:0] f_rw(tag_t t); return PHY_REG_BITS'(t + 40);    endfunction
  function automatic logic [PW-1:0]           f_pl(tag_t t); return 32'hC0DE_0000 + 32'(t) * 32'h0101; endfunction

  // Argument order: in_valid, rob, rs_rdy, rs_tag, rt_rdy, rt_tag, wb_v, wb_tag,
  // iss_ready, flush | expected count, iss_valid, iss_rob_tag (before the edge).
  function automatic vec_t mk(input logic iv, input int rob, input logic rsr, input int rst,
                              input logic rtr, input int rtt, input logic wbv, input int wbt,
                              input logic issr, input logic fl,
                              input int ecnt, input logic eiv, input int etag);
    vec_t v;
    v.in_valid = iv;   v.rob = tag_t'(rob);
    v.rs_rdy = rsr;    v.rs_tag = tag_t'(rst);
    v.rt_rdy = rtr;    v.rt_tag = tag_t'(rtt);
    v.wb_v = wbv;      v.wb_tag = tag_t'(wbt);
    v.iss_rdy = issr;  v.flush = fl;
    v.e_cnt = ecnt;    v.e_iv = eiv;  v.e_tag = tag_t'(etag);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input vec_t v);
    in_valid    = v.in_valid;
    in_rob_tag  = v.rob;
    in_rs_phy   = f_rs(v.rob);
    in_rt_phy   = f_rt(v.rob);
    in_rw_phy   = f_rw(v.rob);
    in_uses_rw  = v.rob[0];
    in_payload  = f_pl(v.rob);
    in_rs_ready = v.rs_rdy;
    in_rs_tag   = v.rs_tag;
    in_rt_ready = v.rt_rdy;
    in_rt_tag   = v.rt_tag;
    wb_valid    = v.wb_v;
    wb_tag      = v.wb_tag;
    iss_ready   = v.iss_rdy;
    flush       = v.flush;
  endtask

  task automatic sb_pop(input tag_t t);
    int idx = -1;
    foreach (sb[k]) if (idx < 0 && sb[k].rob == t) idx = k;
    n_total++;
    if (idx < 0) begin
      $display("FAIL sb_lookup: issued tag %0h has no expected record", t);
      return;
    end
    n_pass++;
    check("iss_rs_phy",  32'(iss_rs_phy),  32'(sb[idx].rs));
    check("iss_rt_phy",  32'(iss_rt_phy),  32'(sb[idx].rt));
    check("iss_rw_phy",  32'(iss_rw_phy),  32'(sb[idx].rw));
    check("iss_uses_rw", 32'(iss_uses_rw), 32'(sb[idx].urw));
    check("iss_payload", iss_payload,      sb[idx].pl);
    sb.delete(idx);
  endtask

  task automatic cyc(input vec_t v);
    logic inr;
    exp_t e;
    @(negedge clk);
    drive(v);
    #1;
    inr = (v.e_cnt < DEPTH);
    check("count",     32'(count),     32'(v.e_cnt));
    check("in_ready",  32'(in_ready),  32'(inr));
    check("iss_valid", 32'(iss_valid), 32'(v.e_iv));
    if (v.e_iv) check("iss_rob_tag", 32'(iss_rob_tag), 32'(v.e_tag));
    if (v.flush) begin
      sb.delete();
    end else begin
      if (v.e_iv && v.iss_rdy) sb_pop(v.e_tag);
      if (v.in_valid && inr) begin
        e.rob = v.rob; e.rs = f_rs(v.rob); e.rt = f_rt(v.rob); e.rw = f_rw(v.rob);
        e.urw = v.rob[0]; e.pl = f_pl(v.rob);
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic issr, input int ecnt, input logic eiv, input int etag);
    cyc(mk(0, 0, 1, 31, 1, 31, 0, 0, issr, 0, ecnt, eiv, etag));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(mk(0, 0, 1, 31, 1, 31, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_count",     32'(count),     0);
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_iss_valid", 32'(iss_valid), 0);

    // Ordering, wakeup, bypass, enqueue+issue, selection change while stalled.
    tbl.push_back(mk(1, 1, 1, 31, 1, 31, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 1, 31, 1, 31, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 0, 0, 0, 0, 2, 1, 1));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 0, 0, 1, 0, 2, 1, 1));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 0, 0, 1, 0, 1, 1, 2));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0,  5, 1, 31, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 1, 5, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 0, 0, 1, 0, 1, 1, 3));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 1, 31, 0,  7, 1, 7, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 0, 0, 1, 0, 1, 1, 4));
    tbl.push_back(mk(1, 6, 1, 31, 0,  9, 1, 8, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 1, 9, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 7, 1, 31, 1, 31, 0, 0, 1, 0, 1, 1, 6));
    tbl.push_back(mk(1, 8, 0, 10, 1, 31, 0, 0, 1, 0, 1, 1, 7));
    tbl.push_back(mk(1, 9, 1, 31, 1, 31, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 1, 10, 0, 0, 2, 1, 9));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 0, 0, 0, 0, 2, 1, 8));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 0, 0, 1, 0, 2, 1, 8));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 0, 0, 1, 0, 1, 1, 9));
    tbl.push_back(mk(0, 0, 1, 31, 1, 31, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[k]) cyc(tbl[k]);

    // Full queue: slots 0..2 wait on tags 20..22, slots 3..7 ready.
    for (int i = 0; i < 8; i++)
      cyc(mk(1, 16 + i, (i >= 3), (i < 3) ? 20 + i : 31, 1, 31, 0, 0, 0, 0,
             i, (i >= 4), 19));
    cyc(mk(1, 24, 1, 31, 1, 31, 0, 0, 0, 0, 8, 1, 19));
    cyc(mk(1, 25, 1, 31, 1, 31, 0, 0, 1, 0, 8, 1, 19));
    for (int k = 0; k < 4; k++) idle(1, 7 - k, 1, 20 + k);
    cyc(mk(0, 0, 1, 31, 1, 31, 1, 20, 1, 0, 3, 0, 0));
    cyc(mk(0, 0, 1, 31, 1, 31, 1, 21, 1, 0, 3, 1, 16));
    cyc(mk(0, 0, 1, 31, 1, 31, 1, 22, 1, 0, 2, 1, 17));
    idle(1, 1, 1, 18);
    idle(0, 0, 0, 0);

    // Flush with enqueue, issue and a matching writeback in the same cycle.
    for (int i = 0; i < 5; i++)
      cyc(mk(1, 1 + i, (i != 4), (i == 4) ? 12 : 31, 1, 31, 0, 0, 0, 0, i, (i >= 1), 1));
    cyc(mk(1, 6, 1, 31, 1, 31, 1, 12, 1, 1, 5, 1, 1));
    idle(1, 0, 0, 0);
    idle(1, 0, 0, 0);

    // Asynchronous reset in the middle of a cycle with three entries held.
    for (int i = 0; i < 3; i++)
      cyc(mk(1, 1 + i, 1, 31, 1, 31, 0, 0, 0, 0, i, (i >= 1), 1));
    @(negedge clk);
    drive(mk(0, 0, 1, 31, 1, 31, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("pre_rst_count", 32'(count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count",     32'(count),     0);
    check("arst_in_ready",  32'(in_ready),  1);
    check("arst_iss_valid", 32'(iss_valid), 0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_count",     32'(count),     0);
    check("post_rst_iss_valid", 32'(iss_valid), 0);
    idle(0, 0, 0, 0);
    cyc(mk(1, 9, 1, 31, 1, 31, 0, 0, 0, 0, 0, 0, 0));
    idle(1, 1, 1, 9);
    idle(0, 0, 0, 0);

    check("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
# issue_queue

Collapsing, oldest-first issue queue directly downstream of register rename. It accepts renamed micro-ops (physical sources with ready bits and producer ROB tags, physical destination, ROB tag). Sources wake up on ROB writeback-tag broadcasts. Each cycle it offers the oldest entry whose sources are both ready to the execute stage.

## Interface
Parameters:
- DEPTH, 8: number of entries; a power of two, at least 2.
- PAYLOAD_W, 32: opaque decoded micro-op bits (ALU op, immediate, control), carried unchanged.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  mispredict flush; invalidates all entries at the next edge
- in_valid  in  1  renamed micro-op offered
- in_ready  out  1  queue can accept; equals count < DEPTH
- in_rs_phy, in_rt_phy  in  6 each  physical source registers
- in_rs_ready, in_rt_ready  in  1 each  source value already committed
- in_rs_tag, in_rt_tag  in  ROB_DEPTH_BITS each  producer ROB tag of a not-ready source
- in_rw_phy  in  6  physical destination register
- in_uses_rw  in  1  destination is written
- in_rob_tag  in  ROB_DEPTH_BITS  this micro-op's ROB tag
- in_payload  in  PAYLOAD_W  opaque bits
- wb_valid  in  1  writeback broadcast valid
- wb_tag  in  ROB_DEPTH_BITS  ROB tag of the completing producer
- iss_valid  out  1  an eligible entry is offered
- iss_ready  in  1  execute stage accepts
- iss_rs_phy, iss_rt_phy, iss_rw_phy, iss_uses_rw, iss_rob_tag, iss_payload  out  same widths as inputs  fields of the selected entry
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage is slots 0..DEPTH-1. Slot 0 is the oldest. Valid slots are always contiguous from 0 to count-1.
- Enqueue: in_valid && in_ready && !flush writes slot count, or slot count-1 when an issue fires in the same cycle.
- Enqueue bypass: if wb_valid is high and wb_tag equals in_rs_tag (or in_rt_tag) in the enqueue cycle, that source is stored as ready.
- Wakeup: every valid entry with a not-ready source whose tag equals wb_tag sets that source's ready bit when wb_valid is high. Matching a source that is already ready has no effect.
- Select: the lowest-index valid entry with both ready bits set. iss_valid = such an entry exists. The iss_* fields come from that entry; when iss_valid = 0 they are don't-care.
- Issue: iss_valid && iss_ready removes the selected slot. All higher slots shift down by one in the same edge, and their wakeups still apply during the shift.
- count is incremented on enqueue and decremented on issue. When both occur, count is unchanged.
- flush has priority over everything else. At the next edge all slots are invalid and count = 0. Enqueue, issue and wakeup in the flush cycle are discarded. The consumer must treat any issue handshake in the flush cycle as squashed.
- Reset, asynchronous: all slots are invalid and count = 0, so iss_valid = 0 and in_ready = 1 immediately on rst_n falling.

## Timing
- Enqueue-to-issue latency is 1 cycle minimum: an entry written at edge N can be offered in cycle N+1.
- Wakeup-to-issue latency is 1 cycle: a wb in cycle N makes the entry eligible in cycle N+1.
- in_ready depends only on count. A full queue does not accept even if an issue fires in the same cycle.
- iss_valid does not depend on iss_ready.
- The selection may change between cycles while iss_ready is low, for example when an older entry wakes up. The consumer samples the iss_* fields only at a handshake.
- Every output is registered state or combinational from registered state. There are no in_* to iss_* combinational paths.

## Structure
- A shared package, rename_pkg, holds:
  - ROB_DEPTH_BITS;
  - PHY_REG_BITS = 6;
  - iq_entry_t: valid, rs/rt phy, ready and tag fields, rw_phy, uses_rw, rob_tag, payload.
- One sub-module, iq_select, is a parameterized lowest-index priority picker. It takes a DEPTH-bit eligible vector and returns a one-hot grant, an index and an any flag. The shift/collapse logic stays in the top module.

## Test plan
- **Reset:** hold rst_n=0 mid-run with 3 entries present. Expect count=0, iss_valid=0 and in_ready=1 asynchronously, and still so after release.
- **Ordering:** enqueue A (tag 1) and B (tag 2), both with ready sources, iss_ready=0 for 2 cycles, then 1. Expect A to issue, then B the next cycle, and count to go 2, 1, 0.
- **Wakeup:** enqueue C with rs not ready (rs_tag 5), then drive wb_valid=1, wb_tag=5 in cycle N. Expect iss_valid=1 with C in cycle N+1, not in N.
- **Bypass:** enqueue D with rt_tag 7 not ready while wb_tag=7 in the same cycle. Expect D to be eligible the following cycle.
- **Full plus simultaneous events:** fill 8 entries. Expect in_ready=0. Then issue slot 3 while in_valid=1. Expect no enqueue, count=7, and slots 4..7 shifted to 3..6 in order.
- **Flush:** with 5 entries, assert flush together with in_valid, iss_ready and a matching wb. Expect count=0 and iss_valid=0 next cycle, with no new entry written.
